// File: rtl/cdc_event_arbiter.sv
// -----------------------------------------------------------------------------
// cdc_event_arbiter
//
// Purpose:
//   Brings CHANNELS asynchronous event lines into the sysClk_i domain. Each
//   line goes through a 3-flop chain, and its edges are detected and latched
//   as pending events. A round-robin arbiter hands the pending events, one at a
//   time, to a single consumer through a valid/ack handshake.
//
// Handshake:
//   event_valid_o is high while an event is offered. event_id_o and
//   event_level_o stay stable for the whole offer. The offer completes on the
//   first sysClk_i edge that samples event_ack_i=1 while event_valid_o=1.
//   event_valid_o is low in the following cycle, so offers are always
//   separated by at least one idle cycle. event_ack_i is ignored when no offer
//   is present.
//
// Ports:
//   sysClk_i        : single clock for the whole block
//   reset_i         : synchronous, active-high reset
//   async_i         : asynchronous inputs, one per channel
//   event_valid_o   : an event is being offered
//   event_id_o      : channel of the offered event
//   event_level_o   : synchronized level of that channel, captured at grant
//   event_ack_i     : consumer accepts the offered event
//   pending_o       : per-channel pending flags
//   overrun_o       : sticky per-channel flags (edge while already pending)
//   clear_overrun_i : clears all overrun_o bits (a new overrun wins)
//
// Configuration macro:
//   CDC_EVENT_FALLING_EN : when defined, falling edges also raise events.
//                          When undefined, only rising edges do.
// -----------------------------------------------------------------------------
module cdc_event_arbiter #(
    parameter int CHANNELS = 4,
    parameter int ID_W     = $clog2(CHANNELS)
) (
    input  logic                sysClk_i,
    input  logic                reset_i,
    input  logic [CHANNELS-1:0] async_i,
    output logic                event_valid_o,
    output logic [ID_W-1:0]     event_id_o,
    output logic                event_level_o,
    input  logic                event_ack_i,
    output logic [CHANNELS-1:0] pending_o,
    output logic [CHANNELS-1:0] overrun_o,
    input  logic                clear_overrun_i
);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_OFFER = 1'b1
    } state_t;

    state_t state_q, state_d;

    // Synchronizer stages: sync1_q is the synchronized level, and
    // sync2_q is the previous synchronized level.
    logic [CHANNELS-1:0] sync0_q, sync1_q, sync2_q;
    logic [1:0]          arm_q;
    logic [CHANNELS-1:0] pending_q, overrun_q;
    logic [ID_W-1:0]     id_q, id_d;
    logic [ID_W-1:0]     last_q, last_d;
    logic                level_q, level_d;

    logic [CHANNELS-1:0]   rise;
    logic [CHANNELS-1:0]   edge_det;
    logic [CHANNELS-1:0]   ack_clr;
    logic                  ack_take;
    logic                  grant_found;
    logic [ID_W-1:0]       grant_id;
    logic [ID_W:0]         rot_amt;
    logic [2*CHANNELS-1:0] pend_rot;

    // Edge detection, masked until the arm counter saturates. Right after
    // reset the chain ramps up from 0, so an input held high through reset
    // would otherwise look like a rising edge.
    assign rise = sync1_q & ~sync2_q;

`ifdef CDC_EVENT_FALLING_EN
    logic [CHANNELS-1:0] fall;
    assign fall     = ~sync1_q & sync2_q;
    assign edge_det = (arm_q == 2'd3) ? (rise | fall) : '0;
`else
    assign edge_det = (arm_q == 2'd3) ? rise : '0;
`endif

    // Round-robin search. The pending vector is rotated so that bit 0
    // corresponds to channel last+1. The lowest set bit of the rotated vector
    // is then the winner. A rotation by CHANNELS (last = CHANNELS-1) leaves
    // the vector unrotated.
    assign rot_amt  = {1'b0, last_q} + {{ID_W{1'b0}}, 1'b1};
    assign pend_rot = {pending_q, pending_q} >> rot_amt;

    always_comb begin
        int sum;
        grant_found = 1'b0;
        grant_id    = '0;
        sum         = 0;
        for (int k = CHANNELS - 1; k >= 0; k--) begin
            if (pend_rot[k]) begin
                grant_found = 1'b1;
                sum = int'(last_q) + 1 + k;
                if (sum >= CHANNELS) begin
                    sum = sum - CHANNELS;
                end
                grant_id = ID_W'(sum);
            end
        end
    end

    // FSM next-state and handshake decode
    always_comb begin
        state_d  = state_q;
        id_d     = id_q;
        level_d  = level_q;
        last_d   = last_q;
        ack_take = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (grant_found) begin
                    id_d    = grant_id;
                    level_d = sync1_q[grant_id];
                    state_d = ST_OFFER;
                end
            end
            ST_OFFER: begin
                if (event_ack_i) begin
                    ack_take = 1'b1;
                    last_d   = id_q;
                    state_d  = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        ack_clr = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            ack_clr[c] = ack_take && (id_q == ID_W'(c));
        end
    end

    always_ff @(posedge sysClk_i) begin
        if (reset_i) begin
            sync0_q   <= '0;
            sync1_q   <= '0;
            sync2_q   <= '0;
            arm_q     <= 2'd0;
            pending_q <= '0;
            overrun_q <= '0;
            state_q   <= ST_IDLE;
            id_q      <= '0;
            level_q   <= 1'b0;
            last_q    <= ID_W'(CHANNELS - 1);
        end else begin
            sync0_q <= async_i;
            sync1_q <= sync0_q;
            sync2_q <= sync1_q;
            if (arm_q != 2'd3) begin
                arm_q <= arm_q + 2'd1;
            end
            // A new edge on a channel that is being acked re-arms it, and
            // does not count as an overrun.
            pending_q <= (pending_q & ~ack_clr) | edge_det;
            overrun_q <= (clear_overrun_i ? '0 : overrun_q)
                       | (edge_det & pending_q & ~ack_clr);
            state_q   <= state_d;
            id_q      <= id_d;
            level_q   <= level_d;
            last_q    <= last_d;
        end
    end

    assign event_valid_o = (state_q == ST_OFFER);
    assign event_id_o    = id_q;
    assign event_level_o = level_q;
    assign pending_o     = pending_q;
    assign overrun_o     = overrun_q;

endmodule

// File: tb/tb_cdc_event_arbiter.sv
// -----------------------------------------------------------------------------
// tb_cdc_event_arbiter
//
// Self-checking bench for cdc_event_arbiter (CHANNELS=4).
//
// A reference model samples the DUT inputs at every clock edge and keeps a
// short history of sampled input vectors. From that history it derives the
// expected events from the timing rules:
//   - an input change sampled at edge E0 becomes an edge at E1,
//   - the edge becomes pending at E2,
//   - the event can be granted at E3.
// At each grant the model pushes the expected {level,id} into exp_q. A
// monitor running on the falling clock edge pops exp_q when an offer appears,
// and also compares valid, pending and overrun against the model every cycle.
// -----------------------------------------------------------------------------
module tb_cdc_event_arbiter;

  localparam int CH = 4;
  localparam int IW = 2;

  // ---------------- clock / reset ----------------
  logic          clk = 1'b0;
  logic          reset;
  logic [CH-1:0] async_v;
  logic          valid;
  logic [IW-1:0] id;
  logic          level;
  logic          ack;
  logic [CH-1:0] pend;
  logic [CH-1:0] over;
  logic          clr;

  always #5 clk = ~clk;

  cdc_event_arbiter #(.CHANNELS(CH), .ID_W(IW)) dut (
    .sysClk_i        (clk),
    .reset_i         (reset),
    .async_i         (async_v),
    .event_valid_o   (valid),
    .event_id_o      (id),
    .event_level_o   (level),
    .event_ack_i     (ack),
    .pending_o       (pend),
    .overrun_o       (over),
    .clear_overrun_i (clr)
  );

  int n_cmp = 0;
  int n_err = 0;

  logic [IW:0] exp_q[$];  // {level, id}

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [CH-1:0] m_h0 = '0, m_h1 = '0, m_h2 = '0;  // samples n-1, n-2, n-3
  int            m_age = 0;                        // clean edges since reset
  logic [CH-1:0] m_pend = '0;
  logic [CH-1:0] m_over = '0;
  logic          m_offer = 1'b0;
  int            m_id = 0;
  logic          m_level = 1'b0;
  int            m_last = CH - 1;

  initial begin
    logic [CH-1:0] ev, clr_mask;
    int c;
    forever begin
      @(posedge clk);
      if (reset) begin
        m_h0 = '0; m_h1 = '0; m_h2 = '0;
        m_age = 0;
        m_pend = '0; m_over = '0;
        m_offer = 1'b0; m_id = 0; m_level = 1'b0;
        m_last = CH - 1;
      end else begin
        ev = '0;
        if (m_age >= 3) begin
          ev = m_h1 & ~m_h2;
`ifdef CDC_EVENT_FALLING_EN
          ev = ev | (~m_h1 & m_h2);
`endif
        end
        clr_mask = (m_offer && ack) ? (CH'(1) << m_id) : '0;
        m_over = (clr ? '0 : m_over) | (ev & m_pend & ~clr_mask);
        if (m_offer) begin
          if (ack) begin
            m_offer = 1'b0;
            m_last = m_id;
          end
        end else if (m_pend != '0) begin
          for (int k = 1; k <= CH; k++) begin
            c = (m_last + k) % CH;
            if (m_pend[c]) begin
              m_id = c;
              break;
            end
          end
          m_offer = 1'b1;
          m_level = m_h1[m_id];
          exp_q.push_back({m_level, IW'(m_id)});
        end
        m_pend = (m_pend & ~clr_mask) | ev;
        m_h2 = m_h1;
        m_h1 = m_h0;
        m_h0 = async_v;
        if (m_age < 3) m_age++;
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  initial begin
    logic        prev_v;
    logic [IW:0] cur;
    prev_v = 1'b0;
    cur = '0;
    forever begin
      @(negedge clk);
      check("valid", 32'(valid), 32'(m_offer));
      check("pending", 32'(pend), 32'(m_pend));
      check("overrun", 32'(over), 32'(m_over));
      if (valid && !prev_v) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_offer: got id %0d expected no offer at %0t", id, $time);
        end else begin
          cur = exp_q.pop_front();
        end
      end
      if (valid) begin
        check("event_id", 32'(id), 32'(cur[IW-1:0]));
        check("event_level", 32'(level), 32'(cur[IW]));
      end
      prev_v = valid;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_valid(input int budget);
    int t;
    t = 0;
    while (!valid && t < budget) begin
      tick(1);
      t++;
    end
    check("wait_valid_timeout", 32'(valid), 32'd1);
  endtask

  // ---------------- main stimulus ----------------
  initial begin
    reset = 1'b1;
    async_v = 4'b0010;  // channel 1 high through reset
    ack = 1'b0;
    clr = 1'b0;
    tick(3);
    check("reset_valid", 32'(valid), 32'd0);
    check("reset_id", 32'(id), 32'd0);
    check("reset_level", 32'(level), 32'd0);
    check("reset_pending", 32'(pend), 32'd0);
    check("reset_overrun", 32'(over), 32'd0);
    reset = 1'b0;

    // Arm mask: channel 1 held high produces nothing
    tick(10);
    check("arm_mask_pending", 32'(pend), 32'd0);
    check("arm_mask_valid", 32'(valid), 32'd0);

    // Basic event on channel 2
    async_v[2] = 1'b1;
    tick(4);
    check("basic_valid", 32'(valid), 32'd1);
    check("basic_id", 32'(id), 32'd2);
    check("basic_level", 32'(level), 32'd1);
    ack = 1'b1;
    tick(1);
    ack = 1'b0;
    check("basic_ack_valid", 32'(valid), 32'd0);
    check("basic_ack_pending", 32'(pend), 32'd0);

    // Round robin: drain, then 0,1,3 together with ack held high
    async_v = '0;
    ack = 1'b1;
    tick(12);
    async_v = 4'b1011;
    tick(14);
    async_v = '0;
    tick(12);
    ack = 1'b0;

    // Overrun on channel 0
    async_v[0] = 1'b1; tick(2);
    async_v[0] = 1'b0; tick(2);
    async_v[0] = 1'b1; tick(2);
    async_v[0] = 1'b0; tick(6);
    check("overrun_bit0", 32'(over[0]), 32'd1);
    check("overrun_pending0", 32'(pend[0]), 32'd1);
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
    check("overrun_cleared", 32'(over), 32'd0);

    // Edge on channel 0 coinciding with its ack
    async_v[0] = 1'b1;
    tick(2);
    ack = 1'b1;
    tick(1);
    ack = 1'b0;
    check("coincide_pending0", 32'(pend[0]), 32'd1);
    check("coincide_overrun0", 32'(over[0]), 32'd0);
    async_v[0] = 1'b0;
    ack = 1'b1;
    tick(12);
    ack = 1'b0;

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        async_v[$urandom_range(0, CH - 1)] ^= 1'b1;
      end
      ack = ($urandom_range(0, 1) == 1);
      clr = ($urandom_range(0, 7) == 0);
      tick(1);
    end
    clr = 1'b0;

    // Mid-offer reset
    async_v = '0;
    ack = 1'b1;
    tick(20);
    ack = 1'b0;
    async_v[3] = 1'b1;
    wait_valid(20);
    reset = 1'b1;
    tick(1);
    check("midreset_valid", 32'(valid), 32'd0);
    check("midreset_id", 32'(id), 32'd0);
    check("midreset_level", 32'(level), 32'd0);
    check("midreset_pending", 32'(pend), 32'd0);
    check("midreset_overrun", 32'(over), 32'd0);
    reset = 1'b0;
    tick(12);
    check("post_reset_valid", 32'(valid), 32'd0);
    check("post_reset_pending", 32'(pend), 32'd0);

    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/cdc_event_arbiter.md
# cdc_event_arbiter

Multi-channel external event controller. Synchronizes `CHANNELS` asynchronous lines into the `sysClk_i` domain with a 3-flop chain per channel and detects their edges. Each detected edge is latched as a pending event, and pending events are handed one at a time to a single consumer (CPU interrupt/IO logic) through a round-robin valid/ack handshake. It sits between board-level inputs (buttons, UART strobes, external IRQs) and the core's IO port.

## Interface
- `CHANNELS`, default 4: number of async inputs, range 2..16.
- `ID_W`, default `$clog2(CHANNELS)`: width of the channel index.

- `sysClk_i`, in, 1: destination-domain clock, single clock for the whole block.
- `reset_i`, in, 1: synchronous, active-high reset.
- `async_i`, in, `CHANNELS`: asynchronous inputs, one per channel.
- `event_valid_o`, out, 1: an event is offered.
- `event_id_o`, out, `ID_W`: channel of the offered event.
- `event_level_o`, out, 1: synchronized level of that channel, captured at grant.
- `event_ack_i`, in, 1: consumer accepts the offered event.
- `pending_o`, out, `CHANNELS`: per-channel pending flags.
- `overrun_o`, out, `CHANNELS`: sticky flags; an edge arrived while the channel was already pending.
- `clear_overrun_i`, in, 1: clears all `overrun_o` bits.

## Operation
- **Sync chain:** per channel, `s[2:0] <= {s[1:0], async_i[c]}` every cycle.
  - Synchronized level is `s[1]`.
  - Rising edge is `s[2:1]==2'b01`.
  - Falling edge is `s[2:1]==2'b10`.
- **Arm counter:** a 2-bit counter is cleared by reset and increments to saturation at 3. Edge detection is masked until the count reaches 3. An input held high through reset therefore produces no event.
- **Pending:**
  - A detected edge sets `pending[c]`.
  - The ack of channel c clears `pending[c]`.
  - If an edge and an ack on the same channel coincide, pending stays 1 (new event) and no overrun is flagged.
  - If an edge arrives while pending is 1 and the channel is not being acked, `overrun[c]` is set.
  - When `clear_overrun_i` and a new overrun coincide, set wins.
- **FSM:**
  - IDLE: if any pending bit is set, grant the first pending channel searching upward from `last+1` mod `CHANNELS`. Register `event_id_o` and `event_level_o = s[1]` of the granted channel, then go to OFFER. Otherwise stay in IDLE.
  - OFFER: `event_valid_o`=1. Id and level are held stable until ack. On `event_ack_i`=1: clear `pending[id]`, set `last`=id, go to IDLE.
- `event_ack_i` is ignored in IDLE.
- Round-robin pointer `last` resets to `CHANNELS-1`, so channel 0 has first priority.

## Timing
- **Reset values:**
  - `event_valid_o`=0, `event_id_o`=0, `event_level_o`=0.
  - `pending_o`=0, `overrun_o`=0.
  - `s`=0 for all channels, arm counter=0, FSM=IDLE.
- **Edge-to-offer latency** (measured from the first clock edge sampling the new level, E0):
  - Edge is visible after E1.
  - `pending` is set at E2.
  - Grant happens at E3; `event_valid_o`=1 after E3.
- **Handshake:**
  - `event_valid_o` drops on the edge that samples ack=1.
  - At least one IDLE cycle separates offers, so peak throughput is one event per 2 cycles.
- Reset asserted mid-OFFER: valid drops on the next edge and all pending events are discarded.
- Minimum detectable pulse: 2 `sysClk_i` periods (not guaranteed below that).

## Configuration
- `CDC_EVENT_FALLING_EN` defined: both rising and falling edges set pending. `event_level_o` distinguishes them (1=rising, 0=falling when serviced promptly).
- Not defined: only rising edges set pending; falling edges are ignored and never cause an overrun. `event_level_o` is still driven.

## Test plan
- **Basic event:** reset, then raise `async_i[2]` at cycle 10 → `event_valid_o`=1, `event_id_o`=2 after the 3rd edge; ack one cycle later → valid=0 and `pending_o`=0 next cycle.
- **Round robin:** `async_i[0]`, `[1]` and `[3]` rise in the same cycle with ack held high → ids offered in order 0, 1, 3, each valid pulse 1 cycle with 1 IDLE gap.
- **Arm mask:** `async_i[1]` held high through reset and after → no event, `pending_o`=0.
- **Overrun:**
  - Pulse channel 0 twice (2 cycles high, 2 low) with no ack → `overrun_o[0]`=1 and `pending_o[0]`=1.
  - `clear_overrun_i` → `overrun_o`=0.
  - Edge coinciding with ack of the same channel → pending stays 1, no overrun.
- **Falling edge:** with `CDC_EVENT_FALLING_EN`, high then low on channel 3 → two events, levels 1 then 0. Without the macro → one event.
- **Mid-OFFER reset:** assert `reset_i` while valid=1 → all outputs at reset values after one edge; no event after release.
